// File: rtl/sdspi_target_pkg.sv
// Shared types for the SD SPI target (card-side) physical layer.
package sdspi_target_pkg;

  typedef logic [7:0] sdBYTE_t;

  typedef enum logic [1:0] {
    stateDESEL,
    stateLOAD,
    stateSHIFT
  } sdspiTgtState_t;

  localparam sdBYTE_t SdspiIdleByte = 8'hFF;

endpackage

// File: rtl/sdspi_target_sync.sv
// N-stage synchroniser with rise/fall detection on the synchronised level.
module sdspi_target_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/sdspi_target.sv
// SPI mode-3 target: oversamples the initiator's pins, deserialises MOSI bytes
// and serialises queued response bytes (or IdleByte) onto MISO.
module sdspi_target
  import sdspi_target_pkg::*;
#(
  parameter int      SyncStages = 2,
  parameter sdBYTE_t IdleByte   = SdspiIdleByte
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_spiSCLK,
  input  logic    i_spiCS,
  input  logic    i_spiMOSI,
  output logic    o_spiMISO,
  output logic    o_spiMISOOE,
  output sdBYTE_t o_rxData,
  output logic    o_rxValid,
  input  sdBYTE_t i_txData,
  input  logic    i_txLoad,
  output logic    o_txReady,
  output logic    o_selected,
  output logic    o_frameAbort,
  output logic    o_txUnderrun
);

  logic w_unusedSclkLevel;
  logic w_sclkRise;
  logic w_sclkFall;
  logic w_csSync;
  logic w_unusedCsRise;
  logic w_csFall;
  logic w_mosiSync;
  logic w_unusedMosiRise;
  logic w_unusedMosiFall;

  sdspi_target_sync #(.STAGES(SyncStages), .RESET_VAL(1'b1)) u_syncSclk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_spiSCLK),
    .o_q     (w_unusedSclkLevel),
    .o_rise  (w_sclkRise),
    .o_fall  (w_sclkFall)
  );

  sdspi_target_sync #(.STAGES(SyncStages), .RESET_VAL(1'b1)) u_syncCs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_spiCS),
    .o_q     (w_csSync),
    .o_rise  (w_unusedCsRise),
    .o_fall  (w_csFall)
  );

  sdspi_target_sync #(.STAGES(SyncStages), .RESET_VAL(1'b1)) u_syncMosi (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_spiMOSI),
    .o_q     (w_mosiSync),
    .o_rise  (w_unusedMosiRise),
    .o_fall  (w_unusedMosiFall)
  );

  sdspiTgtState_t r_state;
  sdBYTE_t        r_rxShift;
  sdBYTE_t        r_txShift;
  sdBYTE_t        r_hold;
  sdBYTE_t        r_rxData;
  logic           r_holdFull;
  logic [2:0]     r_bitCnt;
  logic           r_riseSeen;
  logic           r_finalRise;
  logic           r_miso;
  logic           r_misoOe;
  logic           r_rxValid;
  logic           r_frameAbort;
  logic           r_txUnderrun;

  logic    w_loadAccept;
  logic    w_finalRise;
  logic    w_reload;
  logic    w_reloadEmpty;
  sdBYTE_t w_reloadByte;

  // A load arriving in the same clk as a reload bypasses the holding register.
  assign w_loadAccept  = i_txLoad & ~r_holdFull;
  assign w_finalRise   = (r_state == stateSHIFT) & ~w_csSync & w_sclkRise & (r_bitCnt == 3'd7);
  assign w_reload      = (r_state == stateLOAD) | w_finalRise;
  assign w_reloadEmpty = ~r_holdFull & ~w_loadAccept;
  assign w_reloadByte  = r_holdFull   ? r_hold   :
                         w_loadAccept ? i_txData : IdleByte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= stateDESEL;
      r_rxShift    <= 8'hFF;
      r_txShift    <= 8'hFF;
      r_hold       <= 8'hFF;
      r_rxData     <= 8'hFF;
      r_holdFull   <= 1'b0;
      r_bitCnt     <= 3'd0;
      r_riseSeen   <= 1'b0;
      r_finalRise  <= 1'b0;
      r_miso       <= 1'b1;
      r_misoOe     <= 1'b0;
      r_rxValid    <= 1'b0;
      r_frameAbort <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_rxValid    <= 1'b0;
      r_frameAbort <= 1'b0;
      r_txUnderrun <= w_reload & w_reloadEmpty;

      if (w_reload) begin
        r_holdFull <= 1'b0;
      end else if (w_loadAccept) begin
        r_hold     <= i_txData;
        r_holdFull <= 1'b1;
      end

      case (r_state)
        stateDESEL: begin
          r_miso      <= 1'b1;
          r_misoOe    <= 1'b0;
          r_bitCnt    <= 3'd0;
          r_riseSeen  <= 1'b0;
          r_finalRise <= 1'b0;
          if (w_csFall) begin
            r_state <= stateLOAD;
          end
        end

        stateLOAD: begin
          r_txShift <= w_reloadByte;
          r_miso    <= w_reloadByte[7];
          r_misoOe  <= 1'b1;
          r_state   <= stateSHIFT;
        end

        stateSHIFT: begin
          if (w_csSync) begin
            r_state      <= stateDESEL;
            r_frameAbort <= (r_bitCnt != 3'd0);
            r_miso       <= 1'b1;
            r_misoOe     <= 1'b0;
          end else if (w_sclkRise) begin
            r_rxShift <= {r_rxShift[6:0], w_mosiSync};
            r_bitCnt  <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_rxData    <= {r_rxShift[6:0], w_mosiSync};
              r_rxValid   <= 1'b1;
              r_txShift   <= w_reloadByte;
              r_finalRise <= 1'b1;
              r_riseSeen  <= 1'b0;
            end else begin
              r_riseSeen  <= 1'b1;
              r_finalRise <= 1'b0;
            end
          end else if (w_sclkFall) begin
            // A fall with no preceding rise is the initiator's leading edge; keep the MSB.
            if (r_riseSeen) begin
              r_txShift <= {r_txShift[6:0], 1'b1};
              r_miso    <= r_txShift[6];
            end else if (r_finalRise) begin
              r_miso <= r_txShift[7];
            end
            r_riseSeen  <= 1'b0;
            r_finalRise <= 1'b0;
          end
        end

        default: r_state <= stateDESEL;
      endcase
    end
  end

  assign o_spiMISO    = r_miso;
  assign o_spiMISOOE  = r_misoOe;
  assign o_rxData     = r_rxData;
  assign o_rxValid    = r_rxValid;
  assign o_txReady    = ~r_holdFull;
  assign o_selected   = ~w_csSync;
  assign o_frameAbort = r_frameAbort;
  assign o_txUnderrun = r_txUnderrun;

endmodule

// File: tb/tb_sdspi_target.sv
// Bench for sdspi_target: a mode-3 initiator model plus a byte-level model of the response queue.
module tb_sdspi_target;

  localparam int SYNC = 2;
  localparam int H    = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spiSCLK = 1'b1;
  logic       spiCS = 1'b1;
  logic       spiMOSI = 1'b1;
  logic       spiMISO;
  logic       spiMISOOE;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] txData = 8'h00;
  logic       txLoad = 1'b0;
  logic       txReady;
  logic       selected;
  logic       frameAbort;
  logic       txUnderrun;

  always #5 clk = ~clk;

  sdspi_target #(.SyncStages(SYNC), .IdleByte(8'hFF)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spiSCLK    (spiSCLK),
    .i_spiCS      (spiCS),
    .i_spiMOSI    (spiMOSI),
    .o_spiMISO    (spiMISO),
    .o_spiMISOOE  (spiMISOOE),
    .o_rxData     (rxData),
    .o_rxValid    (rxValid),
    .i_txData     (txData),
    .i_txLoad     (txLoad),
    .o_txReady    (txReady),
    .o_selected   (selected),
    .o_frameAbort (frameAbort),
    .o_txUnderrun (txUnderrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Pulse monitors: count one-clk pulses and collect received bytes.
  int         rxValidCnt = 0;
  int         underrunCnt = 0;
  int         abortCnt = 0;
  logic [7:0] rxQ[$];

  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      rxValidCnt++;
      rxQ.push_back(rxData);
    end
    if (txUnderrun === 1'b1) underrunCnt++;
    if (frameAbort === 1'b1) abortCnt++;
  end

  // Response-queue model: one holding slot; every reload takes it or yields 8'hFF.
  bit         slotFull = 0;
  logic [7:0] slot = 8'h00;
  int         expUnderruns = 0;

  function automatic logic [7:0] modelReload();
    if (slotFull) begin
      slotFull = 0;
      return slot;
    end
    expUnderruns++;
    return 8'hFF;
  endfunction

  task automatic modelLoad(input logic [7:0] v);
    if (!slotFull) begin
      slot     = v;
      slotFull = 1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    txData = v;
    txLoad = 1'b1;
    tick(1);
    txLoad = 1'b0;
    modelLoad(v);
  endtask

  // loadKind: 0 none, 1 load mid-byte, 2 load in the clk that handles the 8th rise.
  task automatic spiByte(input logic [7:0] mosi, input int loadKind, input logic [7:0] loadVal,
                         output logic [7:0] miso, output int preFinal);
    for (int i = 7; i >= 0; i--) begin
      spiSCLK = 1'b0;
      spiMOSI = mosi[i];
      if (i == 3 && loadKind == 1) begin
        tick(2);
        txData = loadVal;
        txLoad = 1'b1;
        tick(1);
        txLoad = 1'b0;
        tick(H - 3);
      end else begin
        tick(H);
      end
      if (i == 0) preFinal = underrunCnt;
      spiSCLK = 1'b1;
      miso[i] = spiMISO;
      if (i == 0 && loadKind == 2) begin
        tick(SYNC);
        txData = loadVal;
        txLoad = 1'b1;
        tick(1);
        txLoad = 1'b0;
        checkOutput("coincidentLoadReady", {31'd0, txReady}, 32'd1);
        tick(H - SYNC - 1);
      end else begin
        tick(H);
      end
    end
  endtask

  task automatic spiPartial(input logic [7:0] mosi, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spiSCLK = 1'b0;
      spiMOSI = mosi[i];
      tick(H);
      spiSCLK = 1'b1;
      tick(H);
    end
  endtask

  task automatic runFrame(input string tag, input logic [7:0] mosiQ[$], input int kindQ[$],
                          input logic [7:0] valQ[$], input int abortBits, input logic [7:0] abortByte);
    int         rv0, u0, a0, e0, e1, eStart, preFinal;
    logic [7:0] expResp, resp, got;
    rxQ.delete();
    rv0    = rxValidCnt;
    u0     = underrunCnt;
    a0     = abortCnt;
    eStart = expUnderruns;
    e1     = eStart;
    spiCS  = 1'b0;
    tick(H);
    checkOutput({tag, "_selected"}, {31'd0, selected}, 32'd1);
    checkOutput({tag, "_oe"}, {31'd0, spiMISOOE}, 32'd1);
    foreach (mosiQ[i]) begin
      e0      = expUnderruns;
      expResp = modelReload();
      if (i == 0) e1 = expUnderruns;
      if (kindQ[i] == 1) checkOutput({tag, "_readyBeforeLoad"}, {31'd0, txReady}, {31'd0, !slotFull});
      spiByte(mosiQ[i], kindQ[i], valQ[i], resp, preFinal);
      checkOutput({tag, "_miso"}, {24'd0, resp}, {24'd0, expResp});
      if (i == 0) checkOutput({tag, "_underrunFirstByte"}, preFinal - u0, e1 - e0);
      if (kindQ[i] != 0) modelLoad(valQ[i]);
    end
    void'(modelReload());
    if (abortBits > 0) spiPartial(abortByte, abortBits);
    spiCS = 1'b1;
    tick(H);
    checkOutput({tag, "_rxValidCount"}, rxValidCnt - rv0, mosiQ.size());
    checkOutput({tag, "_underrunCount"}, underrunCnt - u0, expUnderruns - eStart);
    checkOutput({tag, "_abortCount"}, abortCnt - a0, (abortBits > 0) ? 1 : 0);
    checkOutput({tag, "_txReady"}, {31'd0, txReady}, {31'd0, !slotFull});
    checkOutput({tag, "_deselOe"}, {31'd0, spiMISOOE}, 32'd0);
    foreach (mosiQ[i]) begin
      got = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
      checkOutput({tag, "_rxData"}, {24'd0, got}, {24'd0, mosiQ[i]});
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, {31'd0, spiMISO}, 32'd1);
    checkOutput({tag, "_oe"}, {31'd0, spiMISOOE}, 32'd0);
    checkOutput({tag, "_rxData"}, {24'd0, rxData}, 32'hFF);
    checkOutput({tag, "_rxValid"}, {31'd0, rxValid}, 32'd0);
    checkOutput({tag, "_txReady"}, {31'd0, txReady}, 32'd1);
    checkOutput({tag, "_selected"}, {31'd0, selected}, 32'd0);
    checkOutput({tag, "_frameAbort"}, {31'd0, frameAbort}, 32'd0);
    checkOutput({tag, "_txUnderrun"}, {31'd0, txUnderrun}, 32'd0);
  endtask

  initial begin
    logic [7:0] mq[$];
    int         kq[$];
    logic [7:0] vq[$];
    int         nb, abortBits;

    #23;
    checkResetOutputs("reset");
    #3 rst_n = 1'b1;
    tick(3);

    $display("[TB] preloaded response");
    applyStimulus(8'hA5);
    checkOutput("preloadReady", {31'd0, txReady}, 32'd0);
    mq = '{8'h40}; kq = '{0}; vq = '{8'h00};
    runFrame("preload", mq, kq, vq, 0, 8'h00);

    $display("[TB] nothing queued");
    mq = '{8'h51};
    runFrame("underrun", mq, kq, vq, 0, 8'h00);

    $display("[TB] back-to-back bytes");
    applyStimulus(8'h01);
    mq = '{8'h00, 8'h11, 8'h22}; kq = '{1, 1, 0}; vq = '{8'h02, 8'h03, 8'h00};
    runFrame("burst", mq, kq, vq, 0, 8'h00);

    $display("[TB] abort mid-byte");
    mq.delete(); kq.delete(); vq.delete();
    runFrame("abort", mq, kq, vq, 4, 8'hC3);
    mq = '{8'h3C}; kq = '{0}; vq = '{8'h00};
    runFrame("afterAbort", mq, kq, vq, 0, 8'h00);

    $display("[TB] async reset mid-byte");
    spiCS = 1'b0;
    tick(H);
    applyStimulus(8'h9E);
    checkOutput("preResetReady", {31'd0, txReady}, 32'd0);
    spiPartial(8'h5A, 3);
    spiSCLK = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    spiCS   = 1'b1;
    spiSCLK = 1'b1;
    #2 rst_n = 1'b1;
    slotFull = 0;
    tick(4);
    mq = '{8'h77}; kq = '{0}; vq = '{8'h00};
    runFrame("postReset", mq, kq, vq, 0, 8'h00);

    $display("[TB] holding register overwrite and bypass");
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    checkOutput("dropReady", {31'd0, txReady}, 32'd0);
    mq = '{8'hAA, 8'hBB}; kq = '{2, 0}; vq = '{8'h56, 8'h00};
    runFrame("bypass", mq, kq, vq, 0, 8'h00);

    $display("[TB] randomized frames");
    for (int f = 0; f < 10; f++) begin
      nb = $urandom_range(0, 3);
      mq.delete(); kq.delete(); vq.delete();
      for (int b = 0; b < nb; b++) begin
        mq.push_back(8'($urandom));
        kq.push_back($urandom_range(0, 2));
        vq.push_back(8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom));
      abortBits = (nb == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      runFrame("random", mq, kq, vq, abortBits, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdspi_target.md
Name: sdspi_target

Overview:
- SPI target (card-side) physical layer: the responder at the other end of the RK8E SD SPI link. It lets the same codebase emulate an SD card, for simulation benches and for loopback self-test against the RK8E SPI initiator.
- It oversamples spiSCLK/spiCS/spiMOSI in the clk domain, deserialises bytes from spiMOSI and serialises response bytes onto spiMISO. A byte-level handshake connects it to a card-emulation command engine.
- Mode 3 wire protocol: SCLK idles high. Data changes on the SCLK falling edge and is sampled on the rising edge, MSB first, one byte per 8 clocks while spiCS is low.

Parameters:
- SyncStages, 2, synchroniser flops on spiSCLK/spiCS/spiMOSI. Allowed values 2..3.
- IdleByte, 8'hFF, byte shifted out when no response is queued.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- spiSCLK  in  1  SPI clock from the initiator.
- spiCS  in  1  chip select, active low.
- spiMOSI  in  1  data from the initiator.
- spiMISO  out  1  data to the initiator.
- spiMISOOE  out  1  MISO output enable; high only while selected.
- rxData  out  8  last received byte (sdBYTE_t).
- rxValid  out  1  one-clk pulse when rxData is updated.
- txData  in  8  next response byte (sdBYTE_t).
- txLoad  in  1  write txData into the holding register.
- txReady  out  1  holding register empty.
- selected  out  1  synchronised, inverted spiCS.
- frameAbort  out  1  one-clk pulse when CS rises mid-byte.
- txUnderrun  out  1  one-clk pulse when IdleByte is substituted.

Behaviour:
- Reset (rst low, async) sets:
  - spiMISO=1, spiMISOOE=0;
  - rxData=8'hFF, rxValid=0, txReady=1;
  - selected=0, frameAbort=0, txUnderrun=0;
  - holding register empty; shift registers = 8'hFF; bitcnt=0;
  - synchroniser flops = 1; state=stateDESEL.
- Synchronisation and edges:
  - Inputs pass through SyncStages flops.
  - Rise/fall detect compares the last two synchronised SCLK samples.
  - Every edge is detected SyncStages+1 clks after the pin changes.
- Clock ratio: correct operation requires each SCLK phase ≥ SyncStages+2 clk periods. The initiator's slow divider always meets this; the fast divider requires the target clk ≥ 2× the initiator clk.
- stateDESEL:
  - spiMISOOE=0, spiMISO=1, bitcnt=0.
  - Synchronised CS falling → stateLOAD.
- stateLOAD (one clk):
  - If the holding register is full, move it to txShift and set txReady=1.
  - Otherwise load IdleByte into txShift and pulse txUnderrun.
  - Drive spiMISO=txShift[7] and spiMISOOE=1, then → stateSHIFT.
- stateSHIFT:
  - SCLK rise: rxShift <= {rxShift[6:0], mosi_sync}, bitcnt+1.
  - At the 8th rise (bitcnt 7→0):
    - rxData <= completed byte; rxValid pulses on the next clk.
    - txShift reloads from the holding register, or from IdleByte with a txUnderrun pulse.
  - SCLK fall after a non-final rise: txShift shifts left 1 and spiMISO <= new txShift[7].
  - SCLK fall after the 8th rise: spiMISO <= reloaded txShift[7], with no extra shift.
  - CS rise → stateDESEL. If bitcnt≠0, pulse frameAbort and discard the partial rxShift (rxValid does not pulse).
- Holding register:
  - txLoad while txReady=1 stores txData and clears txReady next clk.
  - txLoad while txReady=0 is ignored; the current byte is kept.
  - If txLoad coincides with a reload in the same clk, the reload consumes the new txData directly and txReady stays 1.
- Leading SCLK fall: the initiator's first falling edge of a byte, if detected while bitcnt=0 and before any rise, must not shift txShift. The MSB stays driven until the first rise.
- Continuous frames: back-to-back bytes within one CS assertion need no gap. bitcnt wraps 7→0.
- CS rise with a queued holding byte: the holding byte is retained for the next selection.

Decomposition:
- Package sdspi_types gains sdspiTgtState_t (stateDESEL, stateLOAD, stateSHIFT) and the constant SdspiIdleByte=8'hFF. sdBYTE_t is reused from sd_types.
- One sub-module is natural: sdspi_sync, a parameterised N-stage synchroniser with edge detect. It is instantiated once per input, with the reset value 1.

Test Plan:
- Initiator sends 8'h40 with txData=8'hA5 preloaded → rxData=8'h40 with one rxValid pulse; initiator receives 8'hA5; txReady returns to 1.
- Initiator sends 8'h51 with nothing queued → initiator reads 8'hFF; exactly one txUnderrun pulse; rxData=8'h51.
- Three back-to-back bytes 8'h00,8'h11,8'h22 under one CS, with responses 8'h01,8'h02,8'h03 loaded as txReady rises → all bytes are exchanged in order with three rxValid pulses.
- CS raised after 4 SCLK rises of 8'hC3 → frameAbort pulses; no rxValid; next frame 8'h3C is received cleanly.
- rst asserted mid-byte (asynchronously, between clk edges) → all outputs take their reset values immediately; after release, an 8'h77 exchange works.
- txLoad 8'h12 then txLoad 8'h34 without any consumption → initiator receives 8'h12 and 8'h34 is dropped; txLoad coinciding with an 8th rise goes straight to the shift register.
